io_sram_responder: RTL

IO_SRAM_RESPONDER -- requirements
Module: io_sram_responder

---
 rtl/io_sram_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/io_sram_responder.sv
// Burst read/write responder in front of a single-port synchronous SRAM.
// One transaction at a time; reads stream through a 2-entry skid FIFO.
module io_sram_responder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_read_addr,
  input  logic [31:0]       req_read_len,
  input  logic              req_read_addr_valid,
  output logic              req_read_addr_ready,
  output logic [31:0]       resp_read_data,
  output logic              resp_read_data_valid,
  input  logic              resp_read_data_ready,
  input  logic [31:0]       req_write_addr,
  input  logic [31:0]       req_write_len,
  input  logic              req_write_addr_valid,
  output logic              req_write_addr_ready,
  input  logic [31:0]       req_write_data,
  input  logic              req_write_data_valid,
  output logic              req_write_data_ready,
  output logic              resp_write_status,
  output logic              resp_write_status_valid,
  input  logic              resp_write_status_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  output logic [3:0]        sram_we,
  input  logic [31:0]       sram_dout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD      = 2'd1,
    S_WR      = 2'd2,
    S_WR_RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              in_flight_q, in_flight_d;
  logic              pref_wr_q, pref_wr_d;
  logic [31:0]       fifo0_q, fifo1_q;
  logic              fifo_wp_q, fifo_rp_q;
  logic [1:0]        fifo_cnt_q;

  logic       idle_s;
  logic       rd_hs_s, wr_hs_s, wdata_hs_s;
  logic       pop_s, push_s, issue_s;
  logic [2:0] occ_s;
  logic       unused_addr_bits_s;

  assign unused_addr_bits_s = ^{req_read_addr[31:ADDR_W+2], req_read_addr[1:0],
                                req_write_addr[31:ADDR_W+2], req_write_addr[1:0]};

  // Handshake and flow-control decode shared by all three FSM processes
  always_comb begin
    idle_s     = rst && (state_q == S_IDLE);
    rd_hs_s    = idle_s && req_read_addr_valid && (!req_write_addr_valid || !pref_wr_q);
    wr_hs_s    = idle_s && req_write_addr_valid && (!req_read_addr_valid || pref_wr_q);
    wdata_hs_s = rst && (state_q == S_WR) && req_write_data_valid;
    pop_s      = rst && (fifo_cnt_q != 2'd0) && resp_read_data_ready;
    push_s     = in_flight_q;
    // Occupancy counts data already in the FIFO plus the word coming back from SRAM
    occ_s      = {1'b0, fifo_cnt_q} + {2'b00, in_flight_q} - {2'b00, pop_s};
    issue_s    = rst && (state_q == S_RD) && (cnt_q < len_q) && (occ_s < 3'd2);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rd_hs_s) begin
          state_d = (req_read_len == 32'd0) ? S_IDLE : S_RD;
        end else if (wr_hs_s) begin
          state_d = (req_write_len == 32'd0) ? S_WR_RESP : S_WR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (pop_s && (pop_cnt_q + 32'd1 == len_q)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (wdata_hs_s && (cnt_q + 32'd1 == len_q)) begin
          state_d = S_WR_RESP;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR_RESP: begin
        if (resp_write_status_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything is gated by rst so reset forces zeros
  always_comb begin
    req_read_addr_ready     = idle_s && (!req_write_addr_valid || !pref_wr_q);
    req_write_addr_ready    = idle_s && (!req_read_addr_valid || pref_wr_q);
    req_write_data_ready    = rst && (state_q == S_WR);
    resp_read_data_valid    = rst && (fifo_cnt_q != 2'd0);
    resp_read_data          = 32'd0;
    if (resp_read_data_valid) begin
      resp_read_data = fifo_rp_q ? fifo1_q : fifo0_q;
    end else begin
      resp_read_data = 32'd0;
    end
    resp_write_status_valid = rst && (state_q == S_WR_RESP);
    resp_write_status       = rst && (state_q == S_WR_RESP);
    sram_addr               = (issue_s || wdata_hs_s) ? idx_q : {ADDR_W{1'b0}};
    sram_din                = wdata_hs_s ? req_write_data : 32'd0;
    sram_we                 = wdata_hs_s ? 4'hF : 4'h0;
  end

  // Burst bookkeeping: latched length, word index, beat counters, arbitration history
  always_comb begin
    len_d       = len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pop_cnt_d   = pop_cnt_q;
    pref_wr_d   = pref_wr_q;
    in_flight_d = issue_s;
    if (rd_hs_s) begin
      len_d     = req_read_len;
      idx_d     = req_read_addr[ADDR_W+1:2];
      cnt_d     = 32'd0;
      pop_cnt_d = 32'd0;
      pref_wr_d = 1'b1;
    end else if (wr_hs_s) begin
      len_d     = req_write_len;
      idx_d     = req_write_addr[ADDR_W+1:2];
      cnt_d     = 32'd0;
      pref_wr_d = 1'b0;
    end else if (issue_s || wdata_hs_s) begin
      idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      cnt_d = cnt_q + 32'd1;
    end else begin
      idx_d = idx_q;
    end
    if (pop_s) begin
      pop_cnt_d = pop_cnt_q + 32'd1;
    end else begin
      pop_cnt_d = pop_cnt_d;
    end
  end

  // Datapath registers and the read-return FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= 32'd0;
      idx_q       <= {ADDR_W{1'b0}};
      cnt_q       <= 32'd0;
      pop_cnt_q   <= 32'd0;
      in_flight_q <= 1'b0;
      pref_wr_q   <= 1'b0;
      fifo0_q     <= 32'd0;
      fifo1_q     <= 32'd0;
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      in_flight_q <= in_flight_d;
      pref_wr_q   <= pref_wr_d;
      if (push_s) begin
        if (fifo_wp_q) begin
          fifo1_q <= sram_dout;
        end else begin
          fifo0_q <= sram_dout;
        end
        fifo_wp_q <= ~fifo_wp_q;
      end
      if (pop_s) begin
        fifo_rp_q <= ~fifo_rp_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule
